ramb_dp_param: RTL and testbench

- Parametrised single-clock true dual-port block RAM; generalises the fixed 2-bit x 2048 dual-port RAM primitive.
- Configurable data width, depth, per-port write mode and memory initialisation.
- Deterministic same-address collision resolution, with a collision flag and a saturating collision counter.
- Serves as the common scratchpad/program store for soft-processor subsystems.

---
 rtl/ramb_dp_param.sv | 162 ++++++++++++++++
 tb/tb_ramb_dp_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb_dp_param.sv
// ramb_dp_param: parametrised single-clock true dual-port block RAM with
// per-port write modes, memory initialisation and same-address collision
// detection (pulse flag plus saturating counter).
// Optional feature: define RAMB_DP_OUTREG_EN to add one output pipeline
// stage per port (read latency 2, DVx delayed together with the data).
module ramb_dp_param #(
  parameter int                     WIDTH        = 8,
  parameter int                     DEPTH        = 512,
  parameter int                     AW           = 9,
  parameter int                     WRITE_MODE_A = 0,
  parameter int                     WRITE_MODE_B = 0,
  parameter logic [DEPTH*WIDTH-1:0] INIT         = '0,
  parameter int                     CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic             WEA,
  input  logic             RSTA,
  input  logic [AW-1:0]    ADDRA,
  input  logic [WIDTH-1:0] DIA,
  output logic [WIDTH-1:0] DOA,
  output logic             DVA,
  input  logic             ENB,
  input  logic             WEB,
  input  logic             RSTB,
  input  logic [AW-1:0]    ADDRB,
  input  logic [WIDTH-1:0] DIB,
  output logic [WIDTH-1:0] DOB,
  output logic             DVB,
  output logic             COLL,
  output logic [CNT_W-1:0] COLL_CNT
);

  localparam int WRITE_FIRST = 0;
  localparam int READ_FIRST  = 1;

  if (AW != $clog2(DEPTH) || (1 << AW) != DEPTH) begin : g_param_check
    $error("ramb_dp_param: DEPTH must be a power of two equal to 2**AW");
  end

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t init_contents();
    mem_t m;
    for (int n = 0; n < DEPTH; n++) begin
      m[n] = INIT[n*WIDTH +: WIDTH];
    end
    return m;
  endfunction

  mem_t mem = init_contents();

  logic [WIDTH-1:0] doa_q;
  logic [WIDTH-1:0] dob_q;
  logic             dva_q;
  logic             dvb_q;
  logic             coll_now;

  assign coll_now = ENA & ENB & (ADDRA == ADDRB) & (WEA | WEB);

  // Storage update; port A is written last so it wins a same-address double write
  always_ff @(posedge CLK) begin
    if (ENB && WEB) mem[ADDRB] <= DIB;
    if (ENA && WEA) mem[ADDRA] <= DIA;
  end

  // Port A first output register; reads see pre-write contents, so a colliding reader gets old data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      doa_q <= '0;
      dva_q <= 1'b0;
    end else if (!ENA) begin
      dva_q <= 1'b0;
    end else if (RSTA) begin
      doa_q <= '0;
      dva_q <= 1'b0;
    end else if (!WEA) begin
      doa_q <= mem[ADDRA];
      dva_q <= 1'b1;
    end else if (WRITE_MODE_A == WRITE_FIRST) begin
      doa_q <= DIA;
      dva_q <= 1'b1;
    end else if (WRITE_MODE_A == READ_FIRST) begin
      doa_q <= mem[ADDRA];
      dva_q <= 1'b1;
    end else begin
      dva_q <= 1'b0;
    end
  end

  // Port B first output register, same rules as port A with its own write mode
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dob_q <= '0;
      dvb_q <= 1'b0;
    end else if (!ENB) begin
      dvb_q <= 1'b0;
    end else if (RSTB) begin
      dob_q <= '0;
      dvb_q <= 1'b0;
    end else if (!WEB) begin
      dob_q <= mem[ADDRB];
      dvb_q <= 1'b1;
    end else if (WRITE_MODE_B == WRITE_FIRST) begin
      dob_q <= DIB;
      dvb_q <= 1'b1;
    end else if (WRITE_MODE_B == READ_FIRST) begin
      dob_q <= mem[ADDRB];
      dvb_q <= 1'b1;
    end else begin
      dvb_q <= 1'b0;
    end
  end

  // Collision pulse and saturating collision count, one cycle after the clash
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COLL     <= 1'b0;
      COLL_CNT <= '0;
    end else begin
      COLL <= coll_now;
      if (coll_now && (COLL_CNT != '1)) COLL_CNT <= COLL_CNT + 1'b1;
    end
  end

`ifdef RAMB_DP_OUTREG_EN
  // Port A final stage: loads every cycle, cleared by a qualified RSTA
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOA <= '0;
      DVA <= 1'b0;
    end else if (ENA && RSTA) begin
      DOA <= '0;
      DVA <= 1'b0;
    end else begin
      DOA <= doa_q;
      DVA <= dva_q;
    end
  end

  // Port B final stage: loads every cycle, cleared by a qualified RSTB
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOB <= '0;
      DVB <= 1'b0;
    end else if (ENB && RSTB) begin
      DOB <= '0;
      DVB <= 1'b0;
    end else begin
      DOB <= dob_q;
      DVB <= dvb_q;
    end
  end
`else
  assign DOA = doa_q;
  assign DVA = dva_q;
  assign DOB = dob_q;
  assign DVB = dvb_q;
`endif

endmodule

// File: tb/tb_ramb_dp_param.sv
// tb_ramb_dp_param: scoreboard bench for ramb_dp_param. Two instances share
// the same stimulus and cover all three write modes; a reference model of
// the RAM predicts per-cycle levels and read-data strobes.
module tb_ramb_dp_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CNT_W = 2;
  localparam logic [DEPTH*WIDTH-1:0] INIT_VAL = 128'hF0E1D2C3B49655877869114BA52D1E0F;

  typedef struct {
    int         edge_no;
    logic [7:0] dat;
  } rd_t;

  typedef struct {
    int              edge_no;
    logic [3:0][7:0] dout;
    logic [3:0]      dv;
    logic            coll;
    logic [1:0]      cnt;
  } st_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ena  = 1'b0;
  logic       wea  = 1'b0;
  logic       rsta = 1'b0;
  logic [3:0] addra = '0;
  logic [7:0] dia  = '0;
  logic       enb  = 1'b0;
  logic       web  = 1'b0;
  logic       rstb = 1'b0;
  logic [3:0] addrb = '0;
  logic [7:0] dib  = '0;

  logic [7:0] do_w  [4];
  logic       dv_w  [4];
  logic       coll_w[2];
  logic [1:0] cnt_w [2];

  rd_t        rdq [4][$];
  st_t        stq [$];
  st_t        mon_s;
  rd_t        mon_r;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] exp_do [4];
  logic [1:0] exp_cnt = '0;
  int         edge_cnt = 0;
  int         total = 0;
  int         bad = 0;

  // Instance 0: A WRITE_FIRST, B READ_FIRST
  ramb_dp_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .WRITE_MODE_A(0), .WRITE_MODE_B(1),
    .INIT(INIT_VAL), .CNT_W(CNT_W)
  ) u0 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(do_w[0]), .DVA(dv_w[0]),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(do_w[1]), .DVB(dv_w[1]),
    .COLL(coll_w[0]), .COLL_CNT(cnt_w[0])
  );

  // Instance 1: A NO_CHANGE, B WRITE_FIRST
  ramb_dp_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .WRITE_MODE_A(2), .WRITE_MODE_B(0),
    .INIT(INIT_VAL), .CNT_W(CNT_W)
  ) u1 (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .RSTA(rsta), .ADDRA(addra), .DIA(dia), .DOA(do_w[2]), .DVA(dv_w[2]),
    .ENB(enb), .WEB(web), .RSTB(rstb), .ADDRB(addrb), .DIB(dib), .DOB(do_w[3]), .DVB(dv_w[3]),
    .COLL(coll_w[1]), .COLL_CNT(cnt_w[1])
  );

  always #5 clk = ~clk;

  // Count rising edges so expectations can be tagged with the edge they belong to
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Write mode of scoreboard slot i (slot = instance*2 + port)
  function automatic int mode_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the coming edge
  task automatic applyStimulus(input logic r,
                               input logic ea, input logic wa, input logic ra,
                               input logic [3:0] aa, input logic [7:0] da,
                               input logic eb, input logic wb, input logic rb,
                               input logic [3:0] ab, input logic [7:0] db);
    st_t        s;
    logic       c;
    logic       e, w, rs;
    logic [3:0] a;
    logic [7:0] d;
    @(negedge clk);
    #1;
    rst = r; ena = ea; wea = wa; rsta = ra; addra = aa; dia = da;
    enb = eb; web = wb; rstb = rb; addrb = ab; dib = db;
    s.edge_no = edge_cnt + 1;
    s.dv = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) exp_do[i] = '0;
      exp_cnt = '0;
      s.coll = 1'b0;
    end else begin
      c = ea && eb && (aa == ab) && (wa || wb);
      for (int i = 0; i < 4; i++) begin
        e  = i[0] ? eb : ea;
        w  = i[0] ? wb : wa;
        rs = i[0] ? rb : ra;
        a  = i[0] ? ab : aa;
        d  = i[0] ? db : da;
        if (e) begin
          if (rs) begin
            exp_do[i] = '0;
          end else if (!w || mode_of(i) == 1) begin
            exp_do[i] = model_mem[a];
            s.dv[i] = 1'b1;
          end else if (mode_of(i) == 0) begin
            exp_do[i] = d;
            s.dv[i] = 1'b1;
          end
        end
        if (s.dv[i]) rdq[i].push_back('{s.edge_no, exp_do[i]});
      end
      if (eb && wb) model_mem[ab] = db;
      if (ea && wa) model_mem[aa] = da;
      if (c && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      s.coll = c;
    end
    for (int i = 0; i < 4; i++) s.dout[i] = exp_do[i];
    s.cnt = exp_cnt;
    stq.push_back(s);
  endtask

  // Monitor: per-cycle levels plus read-data strobes popped from the scoreboard
  always @(negedge clk) begin
    if (stq.size() > 0 && stq[0].edge_no <= edge_cnt) begin
      mon_s = stq.pop_front();
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("dout%0d@%0d", i, edge_cnt), {24'd0, do_w[i]}, {24'd0, mon_s.dout[i]});
        checkOutput($sformatf("dv%0d@%0d", i, edge_cnt), {31'd0, dv_w[i]}, {31'd0, mon_s.dv[i]});
      end
      for (int u = 0; u < 2; u++) begin
        checkOutput($sformatf("coll%0d@%0d", u, edge_cnt), {31'd0, coll_w[u]}, {31'd0, mon_s.coll});
        checkOutput($sformatf("coll_cnt%0d@%0d", u, edge_cnt), {30'd0, cnt_w[u]}, {30'd0, mon_s.cnt});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (dv_w[i]) begin
        if (rdq[i].size() > 0 && rdq[i][0].edge_no == edge_cnt) begin
          mon_r = rdq[i].pop_front();
          checkOutput($sformatf("rdata%0d@%0d", i, edge_cnt), {24'd0, do_w[i]}, {24'd0, mon_r.dat});
        end else begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_dv%0d@%0d: got dv=1 data=%0h expected no strobe", i, edge_cnt, do_w[i]);
        end
      end else if (rdq[i].size() > 0 && rdq[i][0].edge_no <= edge_cnt) begin
        mon_r = rdq[i].pop_front();
        total++;
        bad++;
        $display("[TB] FAIL missing_dv%0d@%0d: got dv=0 expected dv=1 data=%0h", i, edge_cnt, mon_r.dat);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [DEPTH*WIDTH-1:0] init_v;
    logic       r, ea, wa, ra, eb, wb, rb;
    logic [3:0] aa, ab;
    logic [7:0] da, db;

    init_v = INIT_VAL;
    for (int n = 0; n < DEPTH; n++) model_mem[n] = init_v[n*WIDTH +: WIDTH];
    for (int i = 0; i < 4; i++) exp_do[i] = '0;

    $display("[TB] start");
    applyStimulus(1, 0,0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00);
    applyStimulus(1, 0,0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00);
    // init contents: read addr 3 on A
    applyStimulus(0, 1,0,0,4'd3,8'h00, 0,0,0,4'd0,8'h00);
    applyStimulus(0, 0,0,0,4'd3,8'h00, 0,0,0,4'd0,8'h00);
    // write 8'h22 to addr 5 through A, then read back on both ports
    applyStimulus(0, 1,1,0,4'd5,8'h22, 0,0,0,4'd0,8'h00);
    applyStimulus(0, 1,0,0,4'd5,8'h00, 1,0,0,4'd5,8'h00);
    // READ_FIRST / WRITE_FIRST on port B
    applyStimulus(0, 0,0,0,4'd0,8'h00, 1,1,0,4'd4,8'h99);
    // write/write collision on addr 7
    applyStimulus(0, 1,1,0,4'd7,8'h33, 1,1,0,4'd7,8'h44);
    applyStimulus(0, 1,0,0,4'd7,8'h00, 0,0,0,4'd0,8'h00);
    // read/write collision on addr 9
    applyStimulus(0, 1,0,0,4'd9,8'h00, 1,1,0,4'd9,8'h66);
    applyStimulus(0, 1,0,0,4'd9,8'h00, 0,0,0,4'd0,8'h00);
    // output reset on B while writing addr 2
    applyStimulus(0, 0,0,0,4'd0,8'h00, 1,1,1,4'd2,8'h77);
    applyStimulus(0, 0,0,0,4'd0,8'h00, 1,0,0,4'd2,8'h00);
    // three more collisions to saturate the 2-bit counter
    for (int k = 0; k < 3; k++) applyStimulus(0, 1,1,0,4'd1,8'hC0 + 8'(k), 1,1,0,4'd1,8'hD0 + 8'(k));
    applyStimulus(0, 1,0,0,4'd1,8'h00, 1,0,0,4'd3,8'h00);
    // asynchronous reset mid-cycle: outputs drop before the next edge
    applyStimulus(1, 0,0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("async_rst_do%0d", i), {24'd0, do_w[i]}, 32'd0);
      checkOutput($sformatf("async_rst_dv%0d", i), {31'd0, dv_w[i]}, 32'd0);
    end
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("async_rst_coll%0d", u), {31'd0, coll_w[u]}, 32'd0);
      checkOutput($sformatf("async_rst_cnt%0d", u), {30'd0, cnt_w[u]}, 32'd0);
    end
    // memory survives reset
    applyStimulus(0, 1,0,0,4'd7,8'h00, 1,0,0,4'd2,8'h00);
    applyStimulus(0, 1,0,0,4'd9,8'h00, 1,0,0,4'd5,8'h00);

    // randomized traffic on a narrow address window to provoke collisions
    for (int k = 0; k < 300; k++) begin
      r  = ($urandom_range(0, 31) == 0);
      ea = !r && ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) == 1);
      ra = ($urandom_range(0, 7) == 0);
      aa = 4'($urandom_range(0, 3));
      da = 8'($urandom);
      eb = !r && ($urandom_range(0, 3) != 0);
      wb = ($urandom_range(0, 1) == 1);
      rb = ($urandom_range(0, 7) == 0);
      ab = 4'($urandom_range(0, 3));
      db = 8'($urandom);
      applyStimulus(r, ea, wa, ra, aa, da, eb, wb, rb, ab, db);
    end

    // sweep every address on both ports to compare whole contents
    for (int n = 0; n < DEPTH; n++) applyStimulus(0, 1,0,0,4'(n),8'h00, 1,0,0,4'(DEPTH-1-n),8'h00);

    for (int k = 0; k < 3; k++) applyStimulus(0, 0,0,0,4'd0,8'h00, 0,0,0,4'd0,8'h00);
    @(negedge clk);
    #2;
    checkOutput("drain_levels", stq.size(), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("drain_rd%0d", i), rdq[i].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
